// File: rtl/rgb_led_arbiter_if.sv
// Bundle between the LED status requesters and rgb_led_arbiter.
// The master side drives requests, colours and duties; the slave side
// (the arbiter) returns the one-hot grant, the per-channel PWM bits and
// the frame-end strobe.
interface rgb_led_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int PWM_BITS = 3
);
  logic [NUM_REQ-1:0]          req;
  logic [3*NUM_REQ-1:0]        color;
  logic [PWM_BITS*NUM_REQ-1:0] duty;
  logic [NUM_REQ-1:0]          grant;
  logic                        pwm_r;
  logic                        pwm_g;
  logic                        pwm_b;
  logic                        frame;

  modport master (
    output req, color, duty,
    input  grant, pwm_r, pwm_g, pwm_b, frame
  );

  modport slave (
    input  req, color, duty,
    output grant, pwm_r, pwm_g, pwm_b, frame
  );
endinterface

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares the single RGB LED driver between NUM_REQ
// status sources. Ownership only changes on PWM frame boundaries, an
// owner keeps the LED for at least MIN_HOLD frames unless it lets go, and
// one dark frame separates consecutive owners. The three PWM "on" bits
// are produced here and registered so the driver never sees glitches.
// Optional build macro RGB_LED_ARBITER_RR_EN swaps fixed priority
// (index 0 highest) for round-robin starting after the last owner.
module rgb_led_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PWM_BITS = 3,
  parameter int MIN_HOLD = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rgb_led_arbiter_if.slave bus
);

  localparam int                  OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PWM_BITS-1:0] CTR_MAX  = '1;
  localparam logic [3:0]          HOLD_SAT = 4'(MIN_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PWM_BITS-1:0] pwm_ctr, ctr_nxt;
  logic [3:0]          hold_ctr, hold_nxt;
  logic [OW-1:0]       owner, owner_nxt;
  logic [2:0]          col_lat, col_nxt;
  logic [PWM_BITS-1:0] duty_lat, duty_nxt;
  logic [NUM_REQ-1:0]  grant_p1;
  logic [2:0]          pwm_p1;
  logic                frame_p1;
  logic                fe;
  logic                any_req;
  logic                owner_req;
  logic                contender;
  logic [OW-1:0]       winner;

  function automatic logic [2:0] sel_color(input logic [3*NUM_REQ-1:0] c,
                                           input logic [OW-1:0] idx);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (OW'(i) == idx) r = c[3*i +: 3];
    return r;
  endfunction

  function automatic logic [PWM_BITS-1:0] sel_duty(input logic [PWM_BITS*NUM_REQ-1:0] d,
                                                   input logic [OW-1:0] idx);
    logic [PWM_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (OW'(i) == idx) r = d[PWM_BITS*i +: PWM_BITS];
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Hold counter saturates so a long-lived owner never wraps back to "young".
  function automatic logic [3:0] sat_inc(input logic [3:0] h);
    return (h >= HOLD_SAT) ? HOLD_SAT : h + 4'd1;
  endfunction

`ifdef RGB_LED_ARBITER_RR_EN
  logic [OW-1:0] last_owner;

  // Search starts one past the previous owner; the previous owner itself is
  // checked last, so a sole requester still gets the LED back.
  function automatic logic [OW-1:0] pick_rr(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0] last);
    logic [OW-1:0] w;
    int            idx;
    w = last;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (r[OW'(idx)]) w = OW'(idx);
    end
    return w;
  endfunction

  assign winner    = pick_rr(bus.req, last_owner);
  assign contender = |(bus.req & ~onehot(owner));
`else
  // Lowest asserted index wins.
  function automatic logic [OW-1:0] pick_fixed(input logic [NUM_REQ-1:0] r);
    logic [OW-1:0] w;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (r[OW'(i)]) w = OW'(i);
    return w;
  endfunction

  assign winner    = pick_fixed(bus.req);
  assign contender = |(bus.req & ((NUM_REQ'(1) << owner) - NUM_REQ'(1)));
`endif

  assign fe        = (pwm_ctr == CTR_MAX);
  assign any_req   = |bus.req;
  assign owner_req = bus.req[owner];

  // Next-state, hold and colour/duty latch decisions; all change only at frame end.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_ctr;
    col_nxt   = col_lat;
    duty_nxt  = duty_lat;
    ctr_nxt   = pwm_ctr + 1'b1;
    if (fe) begin
      case (state)
        IDLE, BLANK: begin
          if (any_req) begin
            state_nxt = OWNED;
            owner_nxt = winner;
            hold_nxt  = '0;
            col_nxt   = sel_color(bus.color, winner);
            duty_nxt  = sel_duty(bus.duty, winner);
          end else begin
            state_nxt = IDLE;
          end
        end
        OWNED: begin
          hold_nxt = sat_inc(hold_ctr);
          if (!owner_req) begin
            state_nxt = BLANK;
          end else if (contender && (hold_nxt >= HOLD_SAT)) begin
            state_nxt = BLANK;
          end else begin
            col_nxt  = sel_color(bus.color, owner);
            duty_nxt = sel_duty(bus.duty, owner);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state and registered outputs, computed from the values that
  // become current on this edge so every output bit is a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      pwm_ctr  <= '0;
      hold_ctr <= '0;
      owner    <= '0;
      grant_p1 <= '0;
      pwm_p1   <= '0;
      frame_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      pwm_ctr  <= ctr_nxt;
      hold_ctr <= hold_nxt;
      owner    <= owner_nxt;
      grant_p1 <= (state_nxt == OWNED) ? onehot(owner_nxt) : '0;
      pwm_p1   <= {3{(state_nxt == OWNED) && (ctr_nxt < duty_nxt)}} & col_nxt;
      frame_p1 <= (ctr_nxt == CTR_MAX);
    end
  end

  // Colour/duty latches are data only; their use is gated by the owned state.
  always_ff @(posedge i_clk) begin
    col_lat  <= col_nxt;
    duty_lat <= duty_nxt;
  end

`ifdef RGB_LED_ARBITER_RR_EN
  // Remember who last won so the rotation resumes after them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      last_owner <= OW'(NUM_REQ - 1);
    else if ((state_nxt == OWNED) && (state != OWNED))
      last_owner <= owner_nxt;
  end
`endif

  assign bus.grant = grant_p1;
  assign bus.pwm_r = pwm_p1[2];
  assign bus.pwm_g = pwm_p1[1];
  assign bus.pwm_b = pwm_p1[0];
  assign bus.frame = frame_p1;

endmodule

// File: doc/rgb_led_arbiter.md
Name: rgb_led_arbiter

Overview:
Shares the single on-chip RGB LED driver between NUM_REQ status sources, such as the alive-blinky, error and activity indicators. It arbitrates ownership on PWM-frame boundaries with a minimum hold time and a one-frame dark gap between owners. It also generates the three per-channel PWM "on" bits that feed the RGB driver's RGB0PWM/RGB1PWM/RGB2PWM inputs, so no requester touches the driver directly.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is the highest priority.
PWM_BITS, 3, PWM frame counter width; frame = 2^PWM_BITS clocks.
MIN_HOLD, 2, minimum whole frames an owner keeps the LED before it can be preempted; range 1..15.

Ports:
i_clk  in  1  system clock (6 MHz HFOSC).
i_rst_n  in  1  asynchronous, active-low reset.
i_req  in  NUM_REQ  level request per requester.
i_color  in  3*NUM_REQ  per-requester colour; slice [3i+2:3i]; bit2=R, bit1=G, bit0=B.
i_duty  in  PWM_BITS*NUM_REQ  per-requester on-count per frame; 0 = dark.
o_grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
o_pwm_r  out  1  red PWM on bit.
o_pwm_g  out  1  green PWM on bit.
o_pwm_b  out  1  blue PWM on bit.
o_frame  out  1  one-cycle pulse in the last cycle of each frame.

Behaviour:
- Reset (async assert, i_rst_n=0):
  - pwm_ctr=0, state=IDLE, hold_ctr=0.
  - o_grant=0, o_pwm_*=0, o_frame=0.
  - The first frame begins on the first clock after deassertion.
- pwm_ctr:
  - Free-running, wraps from 2^PWM_BITS-1 to 0.
  - "Frame end" (FE) = the cycle with pwm_ctr==max; o_frame=1 only in that cycle.
- All arbitration, state and latch updates occur only on the FE clock edge; their results take effect from frame cycle 0.
- Latches at every FE:
  - owner colour and duty are re-latched from the owner's current inputs.
  - Mid-frame input changes are ignored until the next FE.
- PWM output:
  - In frame cycle k (0..max), o_pwm_x = owned & col_lat[x] & (k < duty_lat).
  - duty=0 gives dark; duty=max gives on for max of 2^PWM_BITS cycles. Full-on is not possible by design.
  - Outputs are registered and glitch-free.
- States:
  - IDLE: outputs dark, o_grant=0. At FE, if any i_req is set, grant the winner, go to OWNED, set hold_ctr=0.
  - OWNED: at each FE, hold_ctr increments, saturating at MIN_HOLD. Then, in priority order:
    - (a) owner's i_req=0 → BLANK, regardless of hold.
    - (b) a higher-priority req exists and hold_ctr (post-increment) ≥ MIN_HOLD → BLANK.
    - (c) otherwise stay; re-latch colour/duty.
  - BLANK: exactly one frame with o_grant=0 and outputs dark. At its FE, re-arbitrate as in IDLE; if no requests, go to IDLE.
- Arbitration: fixed priority, lowest asserted index wins.
- Lower-priority requests never preempt an owner.
- Requests asserted and dropped within one frame (not sampled at an FE) are never seen.
- Simultaneous owner drop and higher-priority request: rule (a) applies; BLANK, then the higher-priority requester wins.
- Reset mid-frame or mid-ownership: returns immediately to reset values, with no completion of the frame.

Optional Feature:
- Macro: RGB_LED_ARBITER_RR_EN.
- Defined:
  - Round-robin replaces fixed priority. The search starts at last_owner+1 modulo NUM_REQ; last_owner resets to NUM_REQ-1.
  - Rule (b) becomes: any other requester waiting and hold_ctr ≥ MIN_HOLD → BLANK, then rotate.
  - A sole requester is never bumped.
- Undefined: fixed priority as described above; no last_owner register is present.

Test Plan:
- Reset release, i_req=0 for 4 frames → o_grant=0, o_pwm_*=0 throughout, o_frame pulses every 8 clocks.
- i_req=0b0010, color1=3'b010, duty1=3 → grant 0b0010 from the frame after the first FE; o_pwm_g high in cycles 0-2 of each frame; r/b stay 0.
- Owner req1 held; i_req[0] rises in owner's first frame (color0=3'b100, duty0=7) → owner kept until hold_ctr=2, then one dark BLANK frame, then grant 0b0001 with o_pwm_r high in 7 of 8 cycles.
- Owner 0; i_req[3] asserted for 10 frames → grant never changes. Owner drops → BLANK frame → grant 0b1000.
- Owner duty changed from 2 to 6 at frame cycle 3 → current frame remains 2 cycles on; the next frame is 6 on.
- Assert i_rst_n=0 mid-frame while owned → o_grant and o_pwm_* go to 0 asynchronously. With RR_EN and reqs 0b0101 held: grants alternate 0001/0100 every MIN_HOLD+1 frames, with BLANK between.
